// File: rtl/multu_sequencer.sv
// Radix-2 shift-add MULTU sequencer that owns the HI/LO pair.
// One multiplier bit is retired per cycle; HI/LO are written only on the final step.
module multu_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             rd_hi,
   input  logic             rd_lo,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplr;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   sum;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             last;

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      last    = 1'b0;
      // acc[WIDTH] is always zero after a shift, so the add can never lose a carry
      sum     = acc + (mplr[0] ? {1'b0, mcand} : '0);
      case (state)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (cnt == CW'(WIDTH - 1)) begin
               last    = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand <= '0;
         mplr  <= '0;
         acc   <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            mcand <= srca;
            mplr  <= srcb;
            acc   <= '0;
            cnt   <= '0;
         end else if (state == RUN) begin
            acc  <= {1'b0, sum[WIDTH:1]};
            mplr <= {sum[0], mplr[WIDTH-1:1]};
            cnt  <= cnt + 1'b1;
            if (last) begin
               hi <= sum[WIDTH:1];
               lo <= {sum[0], mplr[WIDTH-1:1]};
            end
         end
      end
   end

   assign busy   = (state == RUN);
   assign stall  = busy & (start | rd_hi | rd_lo);
   assign result = rd_hi ? hi : lo;

endmodule

// File: tb/tb_multu_sequencer.sv
// Self-checking bench for multu_sequencer: cycle-level behavioural model plus literal anchors.
module tb_multu_sequencer;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, rd_hi, rd_lo;
   logic [W-1:0] srca, srcb;
   logic         stall, busy, done;
   logic [W-1:0] hi, lo, result;

   multu_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .srca(srca), .srcb(srcb),
      .rd_hi(rd_hi), .rd_lo(rd_lo), .stall(stall), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .result(result)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model: cycles left until commit, pending exact product, architected HI/LO
   int           rem;
   logic [63:0]  pend;
   logic [W-1:0] m_hi, m_lo;
   logic         m_done;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Checks DUT against model this cycle, then advances both by one edge.
   task automatic cycle();
      logic m_busy;
      #1;
      m_busy = (rem > 0);
      chk("busy",   64'(busy),   64'(m_busy));
      chk("done",   64'(done),   64'(m_done));
      chk("hi",     64'(hi),     64'(m_hi));
      chk("lo",     64'(lo),     64'(m_lo));
      chk("stall",  64'(stall),  64'(m_busy & (start | rd_hi | rd_lo)));
      chk("result", 64'(result), 64'(rd_hi ? m_hi : m_lo));
      @(posedge clk);
      if (reset) begin
         rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               m_hi   = pend[63:32];
               m_lo   = pend[31:0];
               m_done = 1'b1;
            end
         end else if (start) begin
            pend = 64'(srca) * 64'(srcb);
            rem  = W;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; srca = a; srcb = b;
      cycle();
      start = 1'b0; srca = $urandom; srcb = $urandom;
   endtask

   // Pins both DUT and model to a hand-computed value.
   task automatic lit(input string nm, input logic [63:0] dutv, input logic [63:0] modv,
                      input logic [63:0] exp);
      chk({nm, "_dut"}, dutv, exp);
      chk({nm, "_model"}, modv, exp);
   endtask

   initial begin
      int nbusy;
      reset = 1'b1; start = 1'b0; rd_hi = 1'b0; rd_lo = 1'b0; srca = '0; srcb = '0;
      @(posedge clk); @(negedge clk);
      rem = 0; pend = '0; m_hi = '0; m_lo = '0; m_done = 1'b0;
      cycle();
      lit("rst_busy", 64'(busy), 64'(rem > 0), 64'd0);
      lit("rst_hi", 64'(hi), 64'(m_hi), 64'd0);
      reset = 1'b0;
      idle(2);

      // 3 x 5, busy exactly W cycles
      mul(32'd3, 32'd5);
      nbusy = 0;
      for (int i = 0; i < W; i++) begin
         #1; if (busy) nbusy++;
         cycle();
      end
      chk("busy_cycles", 64'(nbusy), 64'd32);
      lit("m1_done", 64'(done), 64'(m_done), 64'd1);
      lit("m1_hi", 64'(hi), 64'(m_hi), 64'h0);
      lit("m1_lo", 64'(lo), 64'(m_lo), 64'hF);
      idle(2);

      // full-scale operands: carry must survive in the accumulator
      mul('1, '1);
      idle(W);
      lit("ff_hi", 64'(hi), 64'(m_hi), 64'hFFFF_FFFE);
      lit("ff_lo", 64'(lo), 64'(m_lo), 64'h1);
      idle(1);

      // preload, then read HI during a new multiply
      mul(32'h1234_5678, 32'h10);
      idle(W);
      lit("pre_hi", 64'(hi), 64'(m_hi), 64'h1);
      lit("pre_lo", 64'(lo), 64'(m_lo), 64'h2345_6780);
      idle(1);
      mul(32'hFFFF_0000, 32'h100);
      idle(1);
      rd_hi = 1'b1;
      for (int i = 2; i <= W; i++) begin
         #1;
         chk("rdhi_stall", 64'(stall), 64'd1);
         chk("rdhi_old", 64'(result), 64'h1);
         cycle();
      end
      #1;
      chk("rdhi_done_stall", 64'(stall), 64'd0);
      lit("rdhi_new", 64'(result), 64'(m_hi), 64'hFF);
      cycle();
      rd_hi = 1'b0;
      idle(1);

      // start while busy is ignored
      mul(32'd7, 32'd9);
      idle(9);
      start = 1'b1; srca = 32'd2; srcb = 32'd2;
      #1; chk("busy_start_stall", 64'(stall), 64'd1);
      cycle();
      idle(W - 10);
      lit("ign_lo", 64'(lo), 64'(m_lo), 64'd63);
      idle(1);

      // reset mid-run
      mul(32'd11, 32'd13);
      idle(15);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      lit("abort_hi", 64'(hi), 64'(m_hi), 64'd0);
      lit("abort_lo", 64'(lo), 64'(m_lo), 64'd0);
      mul(32'd6, 32'd7);
      idle(W);
      lit("after_rst_lo", 64'(lo), 64'(m_lo), 64'd42);

      // back-to-back: second start in the done cycle
      idle(1);
      mul(32'd5, 32'd5);
      idle(W);
      chk("b2b_done", 64'(done), 64'd1);
      mul(32'h1_0000, 32'h1_0000);
      #1; chk("b2b_busy", 64'(busy), 64'd1);
      idle(W);
      lit("b2b_hi", 64'(hi), 64'(m_hi), 64'h1);
      lit("b2b_lo", 64'(lo), 64'(m_lo), 64'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 2) == 0);
         rd_hi = $urandom_range(0, 1) == 1;
         rd_lo = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 5))
            0: srca = '0;
            1: srca = '1;
            default: srca = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: srcb = 32'd1;
            1: srcb = '1;
            default: srcb = $urandom;
         endcase
         cycle();
      end
      reset = 1'b0; start = 1'b0; rd_hi = 1'b0; rd_lo = 1'b0;
      idle(W + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
